// File: rtl/bf16_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_pkg
//  Description : Shared definitions for the bfloat16 SIMD unit. It holds the
//                operation encodings, special constants, the bf16 field
//                layout and the classification helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package bf16_pkg;

    // Operation select encodings
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_MUL  = 5'b00010;
    localparam logic [4:0] OP_MADD = 5'b00100;
    localparam logic [4:0] OP_MSUB = 5'b00101;
    localparam logic [4:0] OP_DOT9 = 5'b00111;

    localparam logic [15:0] BF16_QNAN = 16'h7FC0;
    localparam logic [15:0] BF16_ZERO = 16'h0000;
    localparam int          EXP_BIAS  = 127;

    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [6:0] mant;
    } bf16_t;

    function automatic logic is_nan(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] != 7'h00);
    endfunction

    function automatic logic is_inf(input logic [15:0] x);
        return (x[14:7] == 8'hFF) && (x[6:0] == 7'h00);
    endfunction

    // Subnormals have exp == 0 and are treated as signed zero
    function automatic logic is_zero(input logic [15:0] x);
        return (x[14:7] == 8'h00);
    endfunction

    // Leading-zero count of an 11-bit extended significand (11 when all zero)
    function automatic logic [3:0] lzc11(input logic [10:0] v);
        logic [3:0] n;
        n = 4'd11;
        for (int i = 0; i <= 10; i++) begin
            if (v[i]) n = 4'(10 - i);
        end
        return n;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bf16_add.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_add
//  Description : Combinational bfloat16 adder/subtractor with guard, round and
//                sticky bits, round-to-nearest-even. The sub input inverts the
//                sign of b before the addition.
//  Revision    : 1.0  initial release
// ============================================================================
module bf16_add
    import bf16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        sub,
    output logic [15:0] sum
);

    logic [15:0]        w_b;
    logic               w_swap;
    logic               w_big_sign;
    logic [7:0]         w_big_exp;
    logic [6:0]         w_big_mant;
    logic [7:0]         w_small_exp;
    logic [6:0]         w_small_mant;
    logic               w_eff_sub;
    logic [7:0]         w_diff;
    logic [3:0]         w_sh;
    logic [19:0]        w_wide;
    logic [10:0]        w_big_ext;
    logic [10:0]        w_small_ext;
    logic [11:0]        w_mag;
    logic [3:0]         w_lz;
    logic [10:0]        w_norm;
    logic               w_round_up;
    logic [7:0]         w_mant_rnd;
    logic signed [9:0]  w_exp_norm;
    logic signed [9:0]  w_exp_fin;

    assign w_b = {b[15] ^ sub, b[14:0]};

    // Order operands by magnitude so the difference is never negative
    assign w_swap       = (w_b[14:0] > a[14:0]);
    assign w_big_sign   = w_swap ? w_b[15]    : a[15];
    assign w_big_exp    = w_swap ? w_b[14:7]  : a[14:7];
    assign w_big_mant   = w_swap ? w_b[6:0]   : a[6:0];
    assign w_small_exp  = w_swap ? a[14:7]    : w_b[14:7];
    assign w_small_mant = w_swap ? a[6:0]     : w_b[6:0];
    assign w_eff_sub    = a[15] ^ w_b[15];

    // Alignment: anything shifted 10 or more places lands entirely in sticky
    assign w_diff      = w_big_exp - w_small_exp;
    assign w_sh        = (w_diff >= 8'd10) ? 4'd10 : w_diff[3:0];
    assign w_wide      = {1'b1, w_small_mant, 12'h000} >> w_sh;
    assign w_big_ext   = {1'b1, w_big_mant, 3'b000};
    assign w_small_ext = {w_wide[19:10], |w_wide[9:0]};

    assign w_mag = w_eff_sub ? ({1'b0, w_big_ext} - {1'b0, w_small_ext})
                             : ({1'b0, w_big_ext} + {1'b0, w_small_ext});

    // A carry shifts right by one (folding the lost bit into sticky);
    // cancellation shifts left by the leading-zero count
    assign w_lz       = lzc11(w_mag[10:0]);
    assign w_norm     = w_mag[11] ? {w_mag[11:2], w_mag[1] | w_mag[0]}
                                  : (w_mag[10:0] << w_lz);
    assign w_exp_norm = w_mag[11] ? (10'(w_big_exp) + 10'd1)
                                  : (10'(w_big_exp) - 10'(w_lz));

    assign w_round_up = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
    assign w_mant_rnd = {1'b0, w_norm[9:3]} + 8'(w_round_up);
    assign w_exp_fin  = w_exp_norm + 10'(w_mant_rnd[7]);

    // Special-case resolution ahead of the normal rounded sum
    always_comb begin
        sum = BF16_ZERO;
        if (is_nan(a) || is_nan(w_b)) begin
            sum = BF16_QNAN;
        end else if (is_inf(a) && is_inf(w_b)) begin
            sum = (a[15] == w_b[15]) ? a : BF16_QNAN;
        end else if (is_inf(a)) begin
            sum = a;
        end else if (is_inf(w_b)) begin
            sum = w_b;
        end else if (is_zero(a) && is_zero(w_b)) begin
            sum = {a[15] & w_b[15], 15'h0000};
        end else if (is_zero(a)) begin
            sum = w_b;
        end else if (is_zero(w_b)) begin
            sum = a;
        end else if (!w_norm[10]) begin
            // Exact cancellation always yields +0
            sum = BF16_ZERO;
        end else if (w_exp_fin >= 10'sd255) begin
            sum = {w_big_sign, 8'hFF, 7'h00};
        end else if (w_exp_fin <= 10'sd0) begin
            sum = {w_big_sign, 15'h0000};
        end else begin
            sum = {w_big_sign, w_exp_fin[7:0], (w_mant_rnd[7] ? 7'h00 : w_mant_rnd[6:0])};
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf16_mul.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_mul
//  Description : Combinational bfloat16 multiplier, round-to-nearest-even,
//                subnormal inputs read as zero, tiny results flushed to zero.
//  Revision    : 1.0  initial release
// ============================================================================
module bf16_mul
    import bf16_pkg::*;
(
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] prod
);

    bf16_t              w_a;
    bf16_t              w_b;
    logic               w_sign;
    logic [15:0]        w_p;
    logic [6:0]         w_mant_pre;
    logic               w_guard;
    logic               w_sticky;
    logic               w_round_up;
    logic [7:0]         w_mant_rnd;
    logic signed [9:0]  w_exp_raw;
    logic signed [9:0]  w_exp_fin;

    assign w_a    = a;
    assign w_b    = b;
    assign w_sign = w_a.sign ^ w_b.sign;

    // 8x8 significand product lies in [1,4): bit 15 set means one extra
    // position of normalisation
    assign w_p        = {1'b1, w_a.mant} * {1'b1, w_b.mant};
    assign w_mant_pre = w_p[15] ? w_p[14:8] : w_p[13:7];
    assign w_guard    = w_p[15] ? w_p[7]    : w_p[6];
    assign w_sticky   = w_p[15] ? (|w_p[6:0]) : (|w_p[5:0]);
    assign w_round_up = w_guard & (w_sticky | w_mant_pre[0]);
    // Bit 7 of the rounded mantissa flags a carry out of all-ones
    assign w_mant_rnd = {1'b0, w_mant_pre} + 8'(w_round_up);

    assign w_exp_raw = 10'(w_a.exp) + 10'(w_b.exp) - 10'(EXP_BIAS) + 10'(w_p[15]);
    assign w_exp_fin = w_exp_raw + 10'(w_mant_rnd[7]);

    // Special-case resolution ahead of the normal rounded product
    always_comb begin
        prod = BF16_ZERO;
        if (is_nan(a) || is_nan(b)) begin
            prod = BF16_QNAN;
        end else if ((is_inf(a) && is_zero(b)) || (is_zero(a) && is_inf(b))) begin
            prod = BF16_QNAN;
        end else if (is_inf(a) || is_inf(b)) begin
            prod = {w_sign, 8'hFF, 7'h00};
        end else if (is_zero(a) || is_zero(b)) begin
            prod = {w_sign, 15'h0000};
        end else if (w_exp_fin >= 10'sd255) begin
            prod = {w_sign, 8'hFF, 7'h00};
        end else if (w_exp_fin <= 10'sd0) begin
            prod = {w_sign, 15'h0000};
        end else begin
            prod = {w_sign, w_exp_fin[7:0], (w_mant_rnd[7] ? 7'h00 : w_mant_rnd[6:0])};
        end
    end

endmodule
`default_nettype wire

// File: rtl/bf16_simd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : bf16_simd_unit
//  Description : Registered bfloat16 arithmetic unit: ADD, SUB, MUL, MADD,
//                MSUB (product rounded before the add) and an optional 9-way
//                dot product. Result appears one clock after the operands.
//                Define BF16_DOT9_EN to build the dot-product datapath; without
//                it DOT9 returns zero and in4..in18 are ignored.
//  Revision    : 1.0  initial release
// ============================================================================
module bf16_simd_unit
    import bf16_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] in1,
    input  logic [15:0] in2,
    input  logic [15:0] in3,
    input  logic [15:0] in4,
    input  logic [15:0] in5,
    input  logic [15:0] in6,
    input  logic [15:0] in7,
    input  logic [15:0] in8,
    input  logic [15:0] in9,
    input  logic [15:0] in10,
    input  logic [15:0] in11,
    input  logic [15:0] in12,
    input  logic [15:0] in13,
    input  logic [15:0] in14,
    input  logic [15:0] in15,
    input  logic [15:0] in16,
    input  logic [15:0] in17,
    input  logic [15:0] in18,
    input  logic [4:0]  funct5,
    output logic [15:0] result
);

    logic [15:0] w_mul_b;
    logic [15:0] w_prod;
    logic        w_is_fma;
    logic        w_add_sub;
    logic [15:0] w_add_a;
    logic [15:0] w_add_b;
    logic [15:0] w_add_sum;
    logic [15:0] w_next;

    // The primary multiplier doubles as the first dot-product lane
`ifdef BF16_DOT9_EN
    assign w_mul_b = (funct5 == OP_DOT9) ? in10 : in2;
`else
    assign w_mul_b = in2;
`endif

    bf16_mul u_mul (
        .a    (in1),
        .b    (w_mul_b),
        .prod (w_prod)
    );

    assign w_is_fma  = (funct5 == OP_MADD) || (funct5 == OP_MSUB);
    assign w_add_sub = (funct5 == OP_SUB)  || (funct5 == OP_MSUB);
    assign w_add_a   = w_is_fma ? w_prod : in1;
    assign w_add_b   = w_is_fma ? in3    : in2;

    bf16_add u_add (
        .a   (w_add_a),
        .b   (w_add_b),
        .sub (w_add_sub),
        .sum (w_add_sum)
    );

`ifdef BF16_DOT9_EN
    logic [15:0] w_dot_x [1:8];
    logic [15:0] w_dot_y [1:8];
    logic [15:0] w_p     [0:8];
    logic [15:0] w_s     [0:7];

    assign w_dot_x = '{in2, in3, in4, in5, in6, in7, in8, in9};
    assign w_dot_y = '{in11, in12, in13, in14, in15, in16, in17, in18};
    assign w_p[0]  = w_prod;

    for (genvar gi = 1; gi < 9; gi++) begin : g_dot_mul
        bf16_mul u_dmul (
            .a    (w_dot_x[gi]),
            .b    (w_dot_y[gi]),
            .prod (w_p[gi])
        );
    end

    // Fixed tree: ((p1+p2)+(p3+p4)) + ((p5+p6)+(p7+p8)), then + p9
    for (genvar gi = 0; gi < 4; gi++) begin : g_dot_pair
        bf16_add u_dadd (
            .a   (w_p[2*gi]),
            .b   (w_p[2*gi+1]),
            .sub (1'b0),
            .sum (w_s[gi])
        );
    end

    bf16_add u_dot_l2a (.a(w_s[0]), .b(w_s[1]), .sub(1'b0), .sum(w_s[4]));
    bf16_add u_dot_l2b (.a(w_s[2]), .b(w_s[3]), .sub(1'b0), .sum(w_s[5]));
    bf16_add u_dot_l3  (.a(w_s[4]), .b(w_s[5]), .sub(1'b0), .sum(w_s[6]));
    bf16_add u_dot_fin (.a(w_s[6]), .b(w_p[8]), .sub(1'b0), .sum(w_s[7]));
`else
    logic w_unused_ops;
    assign w_unused_ops = ^{in4, in5, in6, in7, in8, in9, in10, in11, in12,
                            in13, in14, in15, in16, in17, in18};
`endif

    // Select the datapath result for the requested operation
    always_comb begin
        w_next = BF16_ZERO;
        case (funct5)
            OP_ADD, OP_SUB, OP_MADD, OP_MSUB: w_next = w_add_sum;
            OP_MUL:                           w_next = w_prod;
`ifdef BF16_DOT9_EN
            OP_DOT9:                          w_next = w_s[7];
`endif
            default:                          w_next = BF16_ZERO;
        endcase
    end

    // Output register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            result <= BF16_ZERO;
        end else begin
            result <= w_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bf16_simd_unit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bf16_simd_unit
//  Description : Self-checking bench for bf16_simd_unit. Expected results come
//                from a real-number model that rounds exact values to bf16.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bf16_simd_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  funct5;
    logic [15:0] ops [1:18];
    logic [15:0] result;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model_next;
    logic        check_en;
    string       tag;

    always #5 clk = ~clk;

    bf16_simd_unit dut (
        .clk(clk), .reset(reset),
        .in1(ops[1]),   .in2(ops[2]),   .in3(ops[3]),   .in4(ops[4]),
        .in5(ops[5]),   .in6(ops[6]),   .in7(ops[7]),   .in8(ops[8]),
        .in9(ops[9]),   .in10(ops[10]), .in11(ops[11]), .in12(ops[12]),
        .in13(ops[13]), .in14(ops[14]), .in15(ops[15]), .in16(ops[16]),
        .in17(ops[17]), .in18(ops[18]),
        .funct5(funct5), .result(result)
    );

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // ---------------- reference model (real arithmetic) ----------------
    function automatic real pow2(input int k);
        real r;
        r = 1.0;
        if (k >= 0) for (int i = 0; i < k; i++) r = r * 2.0;
        else        for (int i = 0; i < -k; i++) r = r / 2.0;
        return r;
    endfunction

    function automatic bit f_nan(input logic [15:0] x);
        return x[14:7] == 8'hFF && x[6:0] != 0;
    endfunction
    function automatic bit f_inf(input logic [15:0] x);
        return x[14:7] == 8'hFF && x[6:0] == 0;
    endfunction
    function automatic bit f_zero(input logic [15:0] x);
        return x[14:7] == 8'h00;
    endfunction

    function automatic real val(input logic [15:0] x);
        real m;
        if (f_zero(x)) return 0.0;
        m = (128.0 + real'(x[6:0])) / 128.0 * pow2(int'(x[14:7]) - 127);
        return x[15] ? -m : m;
    endfunction

    // Round a nonzero finite real to bf16 (nearest-even, flush, overflow)
    function automatic logic [15:0] to_bf16(input real x);
        logic s;
        real  m, sc, fr;
        int   e, q;
        s = (x < 0.0);
        m = s ? -x : x;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        sc = m * 128.0;
        q  = int'($floor(sc));
        fr = sc - real'(q);
        if (fr > 0.5 || (fr == 0.5 && q[0])) q++;
        if (q == 256) begin q = 128; e++; end
        if (e + 127 >= 255) return {s, 8'hFF, 7'h00};
        if (e + 127 < 1)    return {s, 15'h0000};
        return {s, 8'(e + 127), 7'(q - 128)};
    endfunction

    function automatic logic [15:0] m_add(input logic [15:0] a, input logic [15:0] b);
        real s;
        if (f_nan(a) || f_nan(b)) return 16'h7FC0;
        if (f_inf(a) && f_inf(b)) return (a[15] == b[15]) ? a : 16'h7FC0;
        if (f_inf(a)) return a;
        if (f_inf(b)) return b;
        if (f_zero(a) && f_zero(b)) return {a[15] & b[15], 15'h0000};
        s = val(a) + val(b);
        if (s == 0.0) return 16'h0000;
        return to_bf16(s);
    endfunction

    function automatic logic [15:0] m_mul(input logic [15:0] a, input logic [15:0] b);
        logic s;
        s = a[15] ^ b[15];
        if (f_nan(a) || f_nan(b)) return 16'h7FC0;
        if ((f_inf(a) && f_zero(b)) || (f_zero(a) && f_inf(b))) return 16'h7FC0;
        if (f_inf(a) || f_inf(b)) return {s, 8'hFF, 7'h00};
        if (f_zero(a) || f_zero(b)) return {s, 15'h0000};
        return to_bf16(val(a) * val(b));
    endfunction

    function automatic logic [15:0] model(input logic rst, input logic [4:0] op);
        logic [15:0] p [0:8];
        if (rst) return 16'h0000;
        case (op)
            5'b00000: return m_add(ops[1], ops[2]);
            5'b00001: return m_add(ops[1], ops[2] ^ 16'h8000);
            5'b00010: return m_mul(ops[1], ops[2]);
            5'b00100: return m_add(m_mul(ops[1], ops[2]), ops[3]);
            5'b00101: return m_add(m_mul(ops[1], ops[2]), ops[3] ^ 16'h8000);
`ifdef BF16_DOT9_EN
            5'b00111: begin
                for (int i = 0; i < 9; i++) p[i] = m_mul(ops[i+1], ops[i+10]);
                return m_add(m_add(m_add(m_add(p[0], p[1]), m_add(p[2], p[3])),
                                   m_add(m_add(p[4], p[5]), m_add(p[6], p[7]))), p[8]);
            end
`endif
            default:  return 16'h0000;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic logic [15:0] rnd_op();
        case ($urandom_range(0, 15))
            0: return 16'($urandom);
            1: case ($urandom_range(0, 8))
                   0: return 16'h0000;
                   1: return 16'h8000;
                   2: return 16'h7F80;
                   3: return 16'hFF80;
                   4: return 16'h7FC1;
                   5: return 16'h0040;
                   6: return 16'h7F7F;
                   7: return 16'hFF7F;
                   default: return 16'h0080;
               endcase
            2: return {1'($urandom), 8'($urandom_range(1, 8)), 7'($urandom)};
            default: return {1'($urandom), 8'($urandom_range(118, 136)), 7'($urandom)};
        endcase
    endfunction

    function automatic logic [4:0] rnd_funct();
        case ($urandom_range(0, 7))
            0: return 5'b00000;
            1: return 5'b00001;
            2: return 5'b00010;
            3: return 5'b00100;
            4: return 5'b00101;
            5: return 5'b00111;
            6: return 5'b00111;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    // Called at a negedge with ops already set; returns at the next negedge
    task automatic cycle(input string name, input logic rst, input logic [4:0] op,
                         input bit lit, input logic [15:0] lit_val);
        reset      = rst;
        funct5     = op;
        model_next = lit ? lit_val : model(rst, op);
        tag        = name;
        check_en   = 1'b1;
        @(negedge clk);
    endtask

    // Single compare process: the value expected after each edge is checked 1 time unit later
    always @(posedge clk) begin : compare
        logic [15:0] want;
        logic        en;
        string       t;
        want = model_next;
        en   = check_en;
        t    = tag;
        #1;
        if (en) check(t, result, want);
    end

    initial begin
        reset      = 1'b1;
        funct5     = 5'b00000;
        check_en   = 1'b0;
        model_next = 16'h0000;
        tag        = "idle";
        for (int i = 1; i <= 18; i++) ops[i] = 16'h0000;

        // Model pins against hand-computed values
        check("pin_add",     m_add(16'h3F80, 16'h3F80), 16'h4000);
        check("pin_tie",     m_add(16'h3F80, 16'h3B80), 16'h3F80);
        check("pin_cancel",  m_add(16'h3F80, 16'hBF80), 16'h0000);
        check("pin_mul",     m_mul(16'h4060, 16'h4110), 16'h41FC);
        check("pin_inf0",    m_mul(16'h7F80, 16'h0000), 16'h7FC0);
        check("pin_madd",    m_add(m_mul(16'h4060, 16'h4110), 16'h4030), 16'h4209);
        check("pin_msub",    m_add(m_mul(16'h4060, 16'h4110), 16'hC030), 16'h41E6);
        check("pin_ovf",     m_add(16'h7F7F, 16'h7F7F), 16'h7F80);
        check("pin_negzero", m_add(16'h8000, 16'h8000), 16'h8000);

        @(negedge clk);
        ops[1] = 16'h3F80; ops[2] = 16'h3F80;
        cycle("reset_a", 1'b1, 5'b00000, 1'b1, 16'h0000);
        cycle("reset_b", 1'b1, 5'b00000, 1'b1, 16'h0000);
        cycle("release_add", 1'b0, 5'b00000, 1'b1, 16'h4000);

        cycle("sub_equal", 1'b0, 5'b00001, 1'b1, 16'h0000);
        ops[2] = 16'h3B80;
        cycle("add_tie_even", 1'b0, 5'b00000, 1'b1, 16'h3F80);
        ops[1] = 16'h4060; ops[2] = 16'h4110; ops[3] = 16'h4030;
        cycle("mul", 1'b0, 5'b00010, 1'b1, 16'h41FC);
        cycle("madd", 1'b0, 5'b00100, 1'b1, 16'h4209);
        cycle("msub", 1'b0, 5'b00101, 1'b1, 16'h41E6);
        for (int i = 4; i <= 18; i++) ops[i] = 16'h3F80;
`ifdef BF16_DOT9_EN
        cycle("dot9", 1'b0, 5'b00111, 1'b1, 16'h41AA);
`else
        cycle("dot9_off", 1'b0, 5'b00111, 1'b1, 16'h0000);
`endif
        cycle("unsupported", 1'b0, 5'b00011, 1'b1, 16'h0000);
        ops[1] = 16'h7F80; ops[2] = 16'h0000;
        cycle("mul_inf_zero", 1'b0, 5'b00010, 1'b1, 16'h7FC0);
        ops[2] = 16'hFF80;
        cycle("add_inf_ninf", 1'b0, 5'b00000, 1'b1, 16'h7FC0);
        ops[1] = 16'h7F7F; ops[2] = 16'h7F7F;
        cycle("add_overflow", 1'b0, 5'b00000, 1'b1, 16'h7F80);
        ops[1] = 16'h0040; ops[2] = 16'h0000;
        cycle("add_subnormal", 1'b0, 5'b00000, 1'b1, 16'h0000);
        ops[1] = 16'h4060; ops[2] = 16'h4110;
        cycle("mid_reset", 1'b1, 5'b00010, 1'b1, 16'h0000);
        cycle("after_reset", 1'b0, 5'b00010, 1'b1, 16'h41FC);

        // Randomized back-to-back traffic, new funct5 every cycle
        for (int n = 0; n < 600; n++) begin
            for (int i = 1; i <= 18; i++) ops[i] = rnd_op();
            cycle("random", ($urandom_range(0, 29) == 0), rnd_funct(), 1'b0, 16'h0000);
        end

        check_en = 1'b0;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
